// File: rtl/sdrc_pkg.sv
// Shared types and field layout for the SDRAM-controller responder model.
package sdrc_pkg;

  localparam int BANK_W    = 2;
  localparam int ROW_W     = 11;
  localparam int COL_W     = 8;
  localparam int DATA_W    = 32;
  localparam int DQM_W     = 4;
  localparam int LEN_W     = 8;
  localparam int ADDR_W    = BANK_W + ROW_W + COL_W;
  localparam int NUM_BANKS = 1 << BANK_W;

  localparam int MRS_PRE_CYCLES = 2;
  localparam logic [DATA_W-1:0] CLOSED_BANK_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_NOP   = 3'b111
  } sdrc_cmd_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_FIXED_WAIT,
    ST_WRITE_BURST,
    ST_READ_WAIT,
    ST_READ_BURST
  } sdrc_state_e;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } sdrc_addr_t;

  function automatic sdrc_addr_t split_addr(input logic [ADDR_W-1:0] a);
    return sdrc_addr_t'(a);
  endfunction

  function automatic logic [ADDR_W-1:0] flat_addr(input logic [BANK_W-1:0] bank,
                                                  input logic [ROW_W-1:0]  row,
                                                  input logic [COL_W-1:0]  col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/sdrc_model_bram.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered read.
module sdrc_model_bram
  import sdrc_pkg::*;
#(
  parameter int AddrWidth = 12
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [DQM_W-1:0]     we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int Depth = 1 << AddrWidth;

  // One byte-wide array per lane keeps each lane a plain inferred RAM.
  for (genvar gi = 0; gi < DQM_W; gi++) begin : g_lane
    logic [7:0] mem [Depth];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) mem[addr] <= wdata[gi*8 +: 8];
        rdata_reg <= mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = rdata_reg;
  end

endmodule

// File: rtl/sdrc_responder_model.sv
// Block-RAM backed responder for the SDRAM controller user interface.
// Define SDRC_MODEL_PROTOCOL_CHECK_EN to enable bank/protocol checks and O_model_error.
module sdrc_responder_model
  import sdrc_pkg::*;
#(
  parameter int MemAddressBitWidth = 12,
  parameter int InitCycles         = 100,
  parameter int Trcd               = 2,
  parameter int ReadLatency        = 4,
  parameter int RefreshCycles      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_sdrc_cmd_en,
  input  logic [2:0]        I_sdrc_cmd,
  input  logic              I_sdrc_precharge_ctrl,
  input  logic              I_sdram_power_down,
  input  logic              I_sdram_selfrefresh,
  input  logic [ADDR_W-1:0] I_sdrc_addr,
  input  logic [DQM_W-1:0]  I_sdrc_dqm,
  input  logic [DATA_W-1:0] I_sdrc_data,
  input  logic [LEN_W-1:0]  I_sdrc_data_len,
  output logic [DATA_W-1:0] O_sdrc_data,
  output logic              O_sdrc_init_done,
  output logic              O_sdrc_cmd_ack,
  output logic              O_model_error
);

`ifdef SDRC_MODEL_PROTOCOL_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  sdrc_state_e state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [BANK_W-1:0] bank_reg, bank_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic ap_reg, ap_next;
  logic bad_reg, bad_next;
  logic [ROW_W-1:0] open_row_reg [NUM_BANKS];
  logic [ROW_W-1:0] open_row_next [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_open_reg, bank_open_next;
  logic ack_reg, ack_next;
  logic init_done_reg;
  logic rd_v_reg, rd_issue;
  logic [DATA_W-1:0] data_reg;

  logic ram_en;
  logic [DQM_W-1:0] ram_we;
  logic [BANK_W-1:0] a_bank;
  logic [ROW_W-1:0]  a_row;
  logic [COL_W-1:0]  a_col;
  logic [MemAddressBitWidth-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  sdrc_cmd_e  cmd;
  sdrc_addr_t req;
  logic cmd_blocked, is_cmd, accept, rw_ok;
  logic fix_go;
  logic [15:0] fix_d;

  assign cmd         = sdrc_cmd_e'(I_sdrc_cmd);
  assign req         = split_addr(I_sdrc_addr);
  assign cmd_blocked = I_sdram_power_down | I_sdram_selfrefresh;
  assign is_cmd      = (I_sdrc_cmd != 3'b111) && (I_sdrc_cmd != 3'b110);
  assign accept      = (state_reg == ST_IDLE) && I_sdrc_cmd_en && !cmd_blocked && is_cmd;
  assign rw_ok       = !(CheckEn && !bank_open_reg[req.bank]);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bank_next      = bank_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    len_next       = len_reg;
    ap_next        = ap_reg;
    bad_next       = bad_reg;
    open_row_next  = open_row_reg;
    bank_open_next = bank_open_reg;
    ack_next       = 1'b0;
    rd_issue       = 1'b0;
    ram_en         = 1'b0;
    ram_we         = '0;
    a_bank         = bank_reg;
    a_row          = row_reg;
    a_col          = col_reg;
    fix_go         = 1'b0;
    fix_d          = 16'd1;

    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == 16'(InitCycles - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          bank_next = req.bank;
          row_next  = open_row_reg[req.bank];
          len_next  = I_sdrc_data_len;
          ap_next   = I_sdrc_precharge_ctrl;
          bad_next  = !rw_ok;
          case (cmd)
            CMD_ACT: begin
              open_row_next[req.bank]  = req.row;
              bank_open_next[req.bank] = 1'b1;
              fix_go = 1'b1;
              fix_d  = 16'(Trcd);
            end
            CMD_PRE: begin
              if (I_sdrc_precharge_ctrl) bank_open_next = '0;
              else                       bank_open_next[req.bank] = 1'b0;
              fix_go = 1'b1;
              fix_d  = 16'(MRS_PRE_CYCLES);
            end
            CMD_MRS: begin
              fix_go = 1'b1;
              fix_d  = 16'(MRS_PRE_CYCLES);
            end
            CMD_REF: begin
              fix_go = 1'b1;
              fix_d  = 16'(RefreshCycles);
            end
            CMD_WRITE: begin
              // Word 0 rides on the command cycle itself.
              ack_next = 1'b1;
              a_bank   = req.bank;
              a_row    = open_row_reg[req.bank];
              a_col    = req.col;
              ram_en   = rw_ok;
              ram_we   = rw_ok ? ~I_sdrc_dqm : '0;
              col_next = req.col + 8'd1;
              cnt_next = 16'd1;
              if (I_sdrc_data_len == '0) begin
                if (I_sdrc_precharge_ctrl) bank_open_next[req.bank] = 1'b0;
              end else begin
                state_next = ST_WRITE_BURST;
              end
            end
            CMD_READ: begin
              ack_next = 1'b1;
              col_next = req.col;
              if (ReadLatency <= 3) begin
                state_next = ST_READ_BURST;
                cnt_next   = '0;
              end else begin
                state_next = ST_READ_WAIT;
                cnt_next   = 16'(ReadLatency - 4);
              end
            end
            default: ;
          endcase
          if (fix_go) begin
            state_next = ST_FIXED_WAIT;
            cnt_next   = fix_d - 16'd1;
            ack_next   = (fix_d == 16'd1);
          end
        end
      end

      ST_FIXED_WAIT: begin
        ack_next = (cnt_reg == 16'd1);
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - 16'd1;
      end

      ST_WRITE_BURST: begin
        ram_en   = !bad_reg;
        ram_we   = bad_reg ? '0 : ~I_sdrc_dqm;
        col_next = col_reg + 8'd1;
        if (cnt_reg == {8'd0, len_reg}) begin
          state_next = ST_IDLE;
          if (ap_reg) bank_open_next[bank_reg] = 1'b0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_READ_WAIT: begin
        if (cnt_reg == '0) state_next = ST_READ_BURST;
        else               cnt_next   = cnt_reg - 16'd1;
      end

      ST_READ_BURST: begin
        // Issue phase for len+1 words, then two cycles to drain RAM and output registers.
        if (cnt_reg <= {8'd0, len_reg}) begin
          rd_issue = 1'b1;
          ram_en   = !bad_reg;
          col_next = col_reg + 8'd1;
        end
        if (cnt_reg == {8'd0, len_reg} + 16'd2) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (ap_reg) bank_open_next[bank_reg] = 1'b0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      default: state_next = ST_INIT;
    endcase
  end

  assign ram_addr = MemAddressBitWidth'(flat_addr(a_bank, a_row, a_col));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      bank_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      len_reg       <= '0;
      ap_reg        <= 1'b0;
      bad_reg       <= 1'b0;
      bank_open_reg <= '0;
      for (int i = 0; i < NUM_BANKS; i++) open_row_reg[i] <= '0;
      ack_reg       <= 1'b0;
      init_done_reg <= 1'b0;
      rd_v_reg      <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bank_reg      <= bank_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      len_reg       <= len_next;
      ap_reg        <= ap_next;
      bad_reg       <= bad_next;
      bank_open_reg <= bank_open_next;
      open_row_reg  <= open_row_next;
      ack_reg       <= ack_next;
      rd_v_reg      <= rd_issue;
      if (state_reg == ST_INIT && state_next == ST_IDLE) init_done_reg <= 1'b1;
      if (rd_v_reg) data_reg <= bad_reg ? CLOSED_BANK_WORD : ram_rdata;
    end
  end

  sdrc_model_bram #(
    .AddrWidth(MemAddressBitWidth)
  ) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (I_sdrc_data),
    .rdata (ram_rdata)
  );

  assign O_sdrc_data      = data_reg;
  assign O_sdrc_init_done = init_done_reg;
  assign O_sdrc_cmd_ack   = ack_reg;

`ifdef SDRC_MODEL_PROTOCOL_CHECK_EN
  logic error_reg, err_event, drop_busy, bad_cmd;

  assign drop_busy = I_sdrc_cmd_en && !cmd_blocked && is_cmd &&
                     (state_reg != ST_IDLE) && (state_reg != ST_INIT);
  assign bad_cmd   = ((cmd == CMD_ACT) && bank_open_reg[req.bank]) ||
                     ((cmd == CMD_REF) && (|bank_open_reg)) ||
                     (((cmd == CMD_READ) || (cmd == CMD_WRITE)) && !bank_open_reg[req.bank]);
  assign err_event = drop_busy || (accept && bad_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         error_reg <= 1'b0;
    else if (err_event) error_reg <= 1'b1;
  end

  assign O_model_error = error_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && err_event)
      $error("sdrc_responder_model: protocol error (cmd %b, dropped %0b)", I_sdrc_cmd, drop_busy);
  end
`endif
`else
  assign O_model_error = 1'b0;
`endif

endmodule

// File: tb/tb_sdrc_responder_model.sv
// Randomized self-checking bench for sdrc_responder_model against a word-array reference model.
module tb_sdrc_responder_model;

  localparam int AW       = 12;
  localparam int RL       = 4;
  localparam int TRCD     = 2;
  localparam int TREF     = 8;
  localparam int INIT_CYC = 100;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

`ifdef SDRC_MODEL_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_en;
  logic [2:0]  cmd;
  logic        pc, pd, sr;
  logic [20:0] addr;
  logic [3:0]  dqm;
  logic [31:0] wdata;
  logic [7:0]  len;
  logic [31:0] rdata;
  logic        init_done, ack, merr;

  sdrc_responder_model #(
    .MemAddressBitWidth(AW), .InitCycles(INIT_CYC), .Trcd(TRCD),
    .ReadLatency(RL), .RefreshCycles(TREF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_precharge_ctrl(pc),
    .I_sdram_power_down(pd), .I_sdram_selfrefresh(sr),
    .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdata), .I_sdrc_data_len(len),
    .O_sdrc_data(rdata), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(ack),
    .O_model_error(merr)
  );

  // Reference model: flat word memory plus per-bank row/open bookkeeping.
  logic [31:0] mem_m [0:(1<<AW)-1];
  logic [10:0] row_m [0:3];
  logic [3:0]  open_m;
  bit          err_m;
  logic [31:0] wd_q [0:255];
  logic [3:0]  wm_q [0:255];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int maddr(input logic [1:0] b, input logic [10:0] r, input int c);
    int flat = (int'(b) << 19) + (int'(r) << 8) + (c % 256);
    return flat % (1 << AW);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] keep);
    logic [31:0] r = old_w;
    for (int i = 0; i < 4; i++)
      if (!keep[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Non-burst command: ack exactly dly cycles after issue, idle the cycle after.
  task automatic do_cmd(input logic [2:0] c, input logic [1:0] b, input logic [10:0] r,
                        input bit p, input int dly, input string name);
    int ack_at = -1;
    int ack_n  = 0;
    $display("%s bank=%0d row=%0d pc=%0b", name, b, r, p);
    cmd_en = 1'b1; cmd = c; addr = {b, r, 8'h00}; pc = p;
    if (c == C_ACT) begin
      if (CHK && open_m[b]) err_m = 1'b1;
      row_m[b]  = r;
      open_m[b] = 1'b1;
    end else if (c == C_PRE) begin
      if (p) open_m = 4'b0000;
      else   open_m[b] = 1'b0;
    end else if (c == C_REF) begin
      if (CHK && (open_m != 4'b0000)) err_m = 1'b1;
    end
    tick();
    cmd_en = 1'b0; pc = 1'b0;
    for (int i = 1; i <= dly + 1; i++) begin
      if (ack) begin
        ack_n++;
        if (ack_at < 0) ack_at = i;
      end
      if (i <= dly) tick();
    end
    check_val({name, "_ack_delay"}, 32'(ack_at), 32'(dly));
    check_val({name, "_ack_count"}, 32'(ack_n), 32'd1);
    check_val({name, "_error"}, 32'(merr), 32'(err_m));
  endtask

  // WRITE burst from wd_q/wm_q; abort_at > 0 asserts reset at cycle T+abort_at.
  task automatic do_write(input logic [1:0] b, input logic [7:0] col, input logic [7:0] ln,
                          input bit p, input int abort_at);
    logic [10:0] r = row_m[b];
    bit ok = !(CHK && !open_m[b]);
    int ack_n = 0;
    bit ack1  = 1'b0;
    int nw    = (abort_at > 0) ? abort_at : int'(ln) + 1;
    $display("WRITE bank=%0d row=%0d col=%02h len=%0d pc=%0b", b, r, col, ln, p);
    if (ok)
      for (int k = 0; k < nw; k++)
        mem_m[maddr(b, r, int'(col) + k)] = merge(mem_m[maddr(b, r, int'(col) + k)], wd_q[k], wm_q[k]);
    if (!ok) err_m = 1'b1;
    if (p && abort_at == 0) open_m[b] = 1'b0;
    cmd_en = 1'b1; cmd = C_WR; addr = {b, 11'(~r), col}; len = ln; pc = p;
    wdata = wd_q[0]; dqm = wm_q[0];
    tick();
    cmd_en = 1'b0; pc = 1'b0;
    for (int k = 1; k <= int'(ln) + 1; k++) begin
      if (ack) begin
        ack_n++;
        if (k == 1) ack1 = 1'b1;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_init_done", 32'(init_done), 32'd0);
        check_val("rst_mid_ack", 32'(ack), 32'd0);
        check_val("rst_mid_data", rdata, 32'd0);
        check_val("rst_mid_error", 32'(merr), 32'd0);
        open_m = 4'b0000; err_m = 1'b0;
        for (int i = 0; i < 4; i++) row_m[i] = '0;
        return;
      end
      if (k <= int'(ln)) begin
        wdata = wd_q[k]; dqm = wm_q[k];
        tick();
      end
    end
    check_val("wr_ack_t1", 32'(ack1), 32'd1);
    check_val("wr_ack_count", 32'(ack_n), 32'd1);
    check_val("wr_error", 32'(merr), 32'(err_m));
  endtask

  // READ burst; inject_at > 0 drives a WRITE cmd_en at T+inject_at (must be dropped).
  task automatic do_read(input logic [1:0] b, input logic [7:0] col, input logic [7:0] ln,
                         input bit p, input int inject_at);
    logic [31:0] e [0:255];
    logic [10:0] r = row_m[b];
    bit ok = !(CHK && !open_m[b]);
    int ack_n = 0;
    bit ack1  = 1'b0;
    $display("READ  bank=%0d row=%0d col=%02h len=%0d pc=%0b inject=%0d", b, r, col, ln, p, inject_at);
    for (int k = 0; k <= int'(ln); k++)
      e[k] = ok ? mem_m[maddr(b, r, int'(col) + k)] : 32'hDEAD_BEEF;
    if (!ok) err_m = 1'b1;
    if (CHK && inject_at > 0) err_m = 1'b1;
    if (p) open_m[b] = 1'b0;
    cmd_en = 1'b1; cmd = C_RD; addr = {b, 11'(~r), col}; len = ln; pc = p;
    tick();
    cmd_en = 1'b0; pc = 1'b0;
    for (int i = 1; i <= RL + int'(ln) + 1; i++) begin
      if (ack) begin
        ack_n++;
        if (i == 1) ack1 = 1'b1;
      end
      if (i >= RL && i <= RL + int'(ln)) check_val("rd_word", rdata, e[i - RL]);
      if (i == RL + int'(ln) + 1) check_val("rd_hold", rdata, e[ln]);
      cmd_en = (i == inject_at);
      if (i == inject_at) begin
        cmd = C_WR; addr = {b, r, col}; len = 8'd0; dqm = 4'h0; wdata = ~e[0];
      end
      if (i < RL + int'(ln) + 1) tick();
    end
    cmd_en = 1'b0;
    check_val("rd_ack_t1", 32'(ack1), 32'd1);
    check_val("rd_ack_count", 32'(ack_n), 32'd1);
    check_val("rd_error", 32'(merr), 32'(err_m));
  endtask

  task automatic wait_init();
    int early = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= INIT_CYC; i++) begin
      if (i == INIT_CYC / 2) begin
        cmd_en = 1'b1; cmd = C_RD; addr = '0; len = 8'd0;
      end else begin
        cmd_en = 1'b0;
      end
      tick();
      if (ack) early++;
      if (i == INIT_CYC - 1) check_val("init_done_early", 32'(init_done), 32'd0);
    end
    cmd_en = 1'b0;
    check_val("init_done_on_time", 32'(init_done), 32'd1);
    check_val("init_read_no_ack", 32'(early), 32'd0);
  endtask

  initial begin
    logic [1:0]  rb;
    logic [7:0]  rc, rl;
    int          op, ack_n;

    rst_n = 1'b0; cmd_en = 1'b0; cmd = C_NOP; pc = 1'b0; pd = 1'b0; sr = 1'b0;
    addr = '0; dqm = '0; wdata = '0; len = '0;
    open_m = '0; err_m = 1'b0;
    for (int i = 0; i < 4; i++) row_m[i] = '0;
    repeat (3) tick();
    check_val("reset_init_done", 32'(init_done), 32'd0);
    check_val("reset_ack", 32'(ack), 32'd0);
    check_val("reset_data", rdata, 32'd0);
    check_val("reset_error", 32'(merr), 32'd0);
    wait_init();

    // Give every backed word a known value.
    for (int r = 0; r < (1 << (AW - 8)); r++) begin
      for (int k = 0; k < 256; k++) begin
        wd_q[k] = $urandom(); wm_q[k] = 4'h0;
      end
      do_cmd(C_ACT, 2'd0, 11'(r), 1'b0, TRCD, "ACT");
      do_write(2'd0, 8'h00, 8'd255, 1'b1, 0);
    end

    do_cmd(C_MRS, 2'd0, 11'd0, 1'b0, 2, "MRS");
    do_cmd(C_REF, 2'd0, 11'd0, 1'b0, TREF, "REF");

    // Masked write and read-back immediately after the burst.
    do_cmd(C_ACT, 2'd1, 11'd5, 1'b0, TRCD, "ACT");
    wd_q[0] = 32'h1111_1111; wd_q[1] = 32'h2222_2222;
    wd_q[2] = 32'h3333_3333; wd_q[3] = 32'h4444_4444;
    wm_q[0] = 4'b0000; wm_q[1] = 4'b0000; wm_q[2] = 4'b0011; wm_q[3] = 4'b0000;
    do_write(2'd1, 8'h00, 8'd3, 1'b0, 0);
    do_read(2'd1, 8'h00, 8'd3, 1'b0, 0);

    // Column wrap inside the row.
    for (int k = 0; k < 3; k++) begin
      wd_q[k] = $urandom(); wm_q[k] = 4'h0;
    end
    do_write(2'd1, 8'hFE, 8'd2, 1'b0, 0);
    do_read(2'd1, 8'hFE, 8'd2, 1'b0, 0);
    do_read(2'd1, 8'h00, 8'd0, 1'b0, 0);

    // Command strobe during a read burst is dropped.
    do_read(2'd1, 8'h10, 8'd7, 1'b0, 2);
    do_read(2'd1, 8'h10, 8'd7, 1'b0, 0);

    // Power-down masks cmd_en.
    $display("PD    ACT bank=2 with power_down");
    pd = 1'b1; cmd_en = 1'b1; cmd = C_ACT; addr = {2'd2, 11'd7, 8'd0};
    tick();
    cmd_en = 1'b0; ack_n = 0;
    repeat (4) begin
      if (ack) ack_n++;
      tick();
    end
    pd = 1'b0;
    check_val("pd_no_ack", 32'(ack_n), 32'd0);

    // Closed bank access.
    do_cmd(C_PRE, 2'd0, 11'd0, 1'b1, 2, "PRE");
    do_read(2'd1, 8'h00, 8'd1, 1'b0, 0);

    // Reset in the middle of a write burst.
    do_cmd(C_ACT, 2'd1, 11'd5, 1'b0, TRCD, "ACT");
    for (int k = 0; k < 16; k++) begin
      wd_q[k] = $urandom(); wm_q[k] = 4'h0;
    end
    do_write(2'd1, 8'h40, 8'd15, 1'b0, 4);
    repeat (2) tick();
    wait_init();
    do_cmd(C_ACT, 2'd1, 11'd5, 1'b0, TRCD, "ACT");
    do_read(2'd1, 8'h40, 8'd15, 1'b0, 0);

    // Random command mix.
    repeat (60) begin
      op = $urandom_range(0, 9);
      rb = 2'($urandom_range(0, 3));
      rc = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 15));
      case (op)
        0, 1: do_cmd(C_ACT, rb, 11'($urandom_range(0, 2047)), 1'b0, TRCD, "ACT");
        2:    do_cmd(C_PRE, rb, 11'd0, 1'($urandom_range(0, 1)), 2, "PRE");
        3:    do_cmd(C_REF, rb, 11'd0, 1'b0, TREF, "REF");
        4:    do_cmd(C_MRS, rb, 11'd0, 1'b0, 2, "MRS");
        5, 6: begin
          for (int k = 0; k <= int'(rl); k++) begin
            wd_q[k] = $urandom(); wm_q[k] = 4'($urandom_range(0, 15));
          end
          do_write(rb, rc, rl, ($urandom_range(0, 3) == 0), 0);
        end
        default: do_read(rb, rc, rl, ($urandom_range(0, 3) == 0), 0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdrc_responder_model.md
# sdrc_responder_model

Synthesizable responder for the SDRAM controller user interface (`I_sdrc_*` / `O_sdrc_*`), backed by on-chip block RAM. It stands in for the vendor SDRAM controller in simulation and in SDRAM-less builds. It connects directly to `ramio`'s SDRAM controller wires and accepts the same command, burst and mask semantics. Memory contents are word-addressed; only the low `MemAddressBitWidth` bits of the flattened address are kept.

## Interface
- `MemAddressBitWidth`, 12: backed words = 2^N; flattened address is truncated to N bits.
- `InitCycles`, 100: cycles from reset release to `O_sdrc_init_done`.
- `Trcd`, 2: ACTIVATE ack delay in cycles.
- `ReadLatency`, 4: cycles from READ `cmd_en` to word 0; must be at least 3.
- `RefreshCycles`, 8: REFRESH ack delay in cycles.

Ports:
- `clk`  in  1  single clock for everything.
- `rst_n`  in  1  asynchronous, active-low reset.
- `I_sdrc_cmd_en`  in  1  one-cycle command strobe.
- `I_sdrc_cmd`  in  3  encodings: MRS 000, REF 001, PRE 010, ACT 011, WRITE 100, READ 101, NOP 111.
- `I_sdrc_precharge_ctrl`  in  1  on READ/WRITE: close the bank after the burst. On PRE: close all banks.
- `I_sdram_power_down`, `I_sdram_selfrefresh`  in  1 each  while either is high, `cmd_en` is ignored.
- `I_sdrc_addr`  in  21  bank[20:19], row[18:8], col[7:0].
- `I_sdrc_dqm`  in  4  per-byte write mask; 1 = keep the existing byte.
- `I_sdrc_data`  in  32  write data.
- `I_sdrc_data_len`  in  8  burst length minus 1 (1..256 words).
- `O_sdrc_data`  out  32  registered read data.
- `O_sdrc_init_done`  out  1  high once init completes; stays high until reset.
- `O_sdrc_cmd_ack`  out  1  one-cycle pulse, exactly one per accepted command.
- `O_model_error`  out  1  sticky protocol-error flag.

## Operation
- **Reset values:** `init_done`, `cmd_ack`, `model_error` = 0; `O_sdrc_data` = 0; all banks closed; state INIT. RAM contents are not reset.
- **Reset mid-burst:** the burst aborts immediately. Words already written stay written.
- **FSM states:** INIT, IDLE, FIXED_WAIT, WRITE_BURST, READ_WAIT, READ_BURST.
- **INIT:** counts `InitCycles`, then goes to IDLE with `init_done` = 1.
- **Command acceptance:** only in IDLE. A `cmd_en` in any other state, or during power_down/selfrefresh, is dropped with no ack.
- **ACT:** latches row into `open_row[bank]` and marks the bank open.
- **PRE:** closes the addressed bank; closes all banks when `precharge_ctrl` = 1.
- **MRS and REF:** no state effect.
- **WRITE:** word k is written to {bank, open_row[bank], col+k mod 256}. For each byte, `dqm` bit = 1 keeps the old byte.
- **READ:** same address sequence as WRITE.
- **Column wrap:** the column wraps within the row; it never carries into the row field.
- **Auto-precharge:** with `precharge_ctrl` = 1 on READ/WRITE, the bank closes after the last word.
- **Address truncation:** the flattened address keeps only its low `MemAddressBitWidth` bits.

## Timing
Let T be the cycle of the accepted `cmd_en`.
- **ACT, MRS, PRE:** ack at T+`Trcd` (MRS and PRE use 2). IDLE from T+ack delay+1.
- **REF:** ack at T+`RefreshCycles`. IDLE from T+`RefreshCycles`+1.
- **WRITE:** word k of `I_sdrc_data`/`I_sdrc_dqm` is sampled at T+k, k = 0..len. Ack at T+1. IDLE from T+len+1, so a `cmd_en` in that cycle is accepted.
- **READ:** ack at T+1. Word k is valid on `O_sdrc_data` during T+`ReadLatency`+k. `O_sdrc_data` holds the last word afterwards. IDLE from T+`ReadLatency`+len+1.
- **Read-after-write:** a READ accepted immediately after a WRITE burst returns the new data (no stale bypass window).

## Configuration
- **`SDRC_MODEL_PROTOCOL_CHECK_EN` defined:**
  - READ/WRITE to a closed bank: executes no RAM access. Read words return 32'hDEAD_BEEF; ack still occurs.
  - Errors that set `O_model_error`: READ/WRITE to a closed bank, REF with any bank open, ACT to an already-open bank, and a dropped `cmd_en` (busy state).
  - Simulation `$error` reports each error.
- **Not defined:** no checks. READ/WRITE use the last latched row regardless of open state. `O_model_error` is tied to 0.

## Structure
- **Package `sdrc_pkg`:**
  - command enum `sdrc_cmd_e` (3-bit).
  - field widths: bank 2, row 11, col 8, data 32, dqm 4, len 8.
  - address slice functions.
  - constant 32'hDEAD_BEEF.
- **Sub-module `sdrc_model_bram`:** single-clock, one port, 32-bit, per-byte write enable, registered read, 1-cycle latency. The FSM compensates to meet `ReadLatency`.

## Test plan
- **Init:** release reset → `init_done` rises exactly 100 cycles later. A READ issued earlier than that gets no ack.
- **Masked write:**
  - ACT bank 1 row 5, then WRITE col 0, len 3, data 0x11111111..0x44444444; word 2 has dqm 4'b0011.
  - READ back → 0x11111111, 0x22222222, 0x3333_xxxx (low bytes keep prior value), 0x44444444.
  - Words appear at T+4..T+7.
- **Column wrap:** WRITE col 0xFE, len 2 → words land at cols 0xFE, 0xFF, 0x00 of the same row. Read back matches.
- **Busy drop:** `cmd_en` WRITE at T+2 of a len-7 READ → no second ack, RAM unchanged. `model_error` = 1 only with the macro defined.
- **Closed bank:** PRE all banks (`precharge_ctrl` = 1), then READ → with the macro, 32'hDEAD_BEEF and error set; without it, data from the last row.
- **Reset mid-burst:** assert `rst_n` low mid-WRITE (len 15, after 4 words) → outputs return to reset values at once. After re-init, words 0..3 are present and words 4..15 are unchanged.
